// File: rtl/dilithium_pkg.sv
`default_nettype none
// ============================================================================
// Module : dilithium_pkg
// Brief  : Shared Dilithium definitions: mode encodings, output field kinds,
//          per-level field sizes and word-count helpers.
// Rev    : 1.0  initial release
// ============================================================================
package dilithium_pkg;

  localparam logic [1:0] MODE_KEYGEN  = 2'b00;
  localparam logic [1:0] MODE_SIGN    = 2'b10;
  localparam logic [1:0] MODE_VERIFY  = 2'b01;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  // Kind of field carried by a segment; the segment ID itself is its position
  typedef enum logic [2:0] {
    FLD_SEED, FLD_S1, FLD_S2, FLD_T0, FLD_T1, FLD_Z, FLD_H, FLD_RES
  } field_e;

  localparam int unsigned SEED_BITS = 256;

  // Packed field size in bits for a given security level (2, 3 or 5)
  function automatic int unsigned field_bits(input field_e f, input int unsigned sec);
    int unsigned b;
    b = 0;
    case (f)
      FLD_SEED: b = SEED_BITS;
      FLD_S1:   b = (sec == 5) ? 5376  : (sec == 3) ? 5120  : 3072;
      FLD_S2:   b = (sec == 5) ? 6144  : (sec == 3) ? 6144  : 3072;
      FLD_T0:   b = (sec == 5) ? 26624 : (sec == 3) ? 19968 : 13312;
      FLD_T1:   b = (sec == 5) ? 20480 : (sec == 3) ? 15360 : 10240;
      FLD_Z:    b = (sec == 5) ? 35840 : (sec == 3) ? 25600 : 18432;
      FLD_H:    b = (sec == 5) ? 664   : (sec == 3) ? 488   : 672;
      default:  b = 0;
    endcase
    return b;
  endfunction

  function automatic int unsigned ceil_words(input int unsigned bits, input int unsigned w);
    return (bits + w - 1) / w;
  endfunction

  // Stream words occupied by a field; the verify result is always one word
  function automatic logic [9:0] field_words(input field_e f, input int unsigned sec,
                                             input int unsigned w);
    if (f == FLD_RES) return 10'd1;
    return 10'(ceil_words(field_bits(f, sec), w));
  endfunction

  // Field kind at segment position idx of a frame in mode m
  function automatic field_e seg_field(input logic [1:0] m, input logic [2:0] idx);
    field_e f;
    f = FLD_RES;
    case (m)
      MODE_KEYGEN: begin
        case (idx)
          3'd3:    f = FLD_S1;
          3'd4:    f = FLD_S2;
          3'd5:    f = FLD_T0;
          3'd6:    f = FLD_T1;
          default: f = FLD_SEED;
        endcase
      end
      MODE_SIGN: begin
        case (idx)
          3'd1:    f = FLD_Z;
          3'd2:    f = FLD_H;
          default: f = FLD_SEED;
        endcase
      end
      MODE_VERIFY: f = FLD_RES;
      default:     f = FLD_RES;
    endcase
    return f;
  endfunction

  // Index of the final segment of a frame in mode m
  function automatic logic [2:0] last_seg(input logic [1:0] m);
    case (m)
      MODE_KEYGEN: return 3'd6;
      MODE_SIGN:   return 3'd2;
      default:     return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dilithium_reg_slice.sv
`default_nettype none
// ============================================================================
// Module : dilithium_reg_slice
// Brief  : One-entry valid/ready register slice with synchronous flush.
// Rev    : 1.0  initial release
// ============================================================================
module dilithium_reg_slice #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  // A new word may enter when the slot is empty or being drained this cycle
  assign in_ready = !out_valid || out_ready;

  // Slot register: load on input handshake, empty on output handshake, hold on stall
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dilithium_out_framer.sv
`default_nettype none
// ============================================================================
// Module : dilithium_out_framer
// Brief  : Tags the Dilithium core output stream with segment ID and
//          first/last markers, enforces per-mode frame length, and forwards
//          words through a one-entry register slice.
// Rev    : 1.0  initial release
// ============================================================================
module dilithium_out_framer
  import dilithium_pkg::*;
#(
  parameter  int HIGH_PERF = 0,
  parameter  int SEC_LEVEL = 2,
  localparam int W         = (HIGH_PERF != 0) ? 64 : 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         abort,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_seg,
  output logic         out_seg_first,
  output logic         out_seg_last,
  output logic         out_frame_last,
  output logic         busy,
  output logic         done,
  output logic         err_mode
);

  localparam int         TW        = W + 6;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [1:0]    mode_q;
  logic [2:0]    seg_idx;
  logic [9:0]    word_cnt;
  logic [9:0]    seg_len;
  logic          seg_last, frame_last, start_ok, accept;
  logic          slice_in_valid, slice_in_ready;
  logic [TW-1:0] slice_in, slice_out;

  // Segment boundary flags for the word currently offered by the core
  always_comb begin
    seg_len    = field_words(seg_field(mode_q, seg_idx), unsigned'(SEC_LEVEL), unsigned'(W));
    seg_last   = (word_cnt == seg_len - 10'd1);
    frame_last = seg_last && (seg_idx == last_seg(mode_q));
    start_ok   = start && !abort && (mode != MODE_ILLEGAL);
    accept     = (state == ST_STREAM) && in_valid && slice_in_ready;
    slice_in   = {frame_last, seg_last, (word_cnt == 10'd0), seg_idx, in_data};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort takes priority over every other event
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_ok) state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (abort)                     state_nxt = ST_IDLE;
        else if (accept && frame_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)                                           state_nxt = ST_IDLE;
        else if (out_valid && out_ready && out_frame_last)   state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Per-state outputs and slice input gating
  always_comb begin
    in_ready       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    err_mode       = 1'b0;
    slice_in_valid = 1'b0;
    case (state)
      ST_IDLE:   err_mode = start && !abort && (mode == MODE_ILLEGAL);
      ST_STREAM: begin
        busy           = 1'b1;
        in_ready       = slice_in_ready;
        slice_in_valid = in_valid;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        done = out_valid && out_ready && out_frame_last && !abort;
      end
      default: ;
    endcase
  end

  // Frame context: latched mode, segment index and word position in the segment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= MODE_KEYGEN;
      seg_idx  <= 3'd0;
      word_cnt <= 10'd0;
    end else if (state == ST_IDLE) begin
      if (start_ok) begin
        mode_q   <= mode;
        seg_idx  <= 3'd0;
        word_cnt <= 10'd0;
      end
    end else if (abort) begin
      seg_idx  <= 3'd0;
      word_cnt <= 10'd0;
    end else if (accept) begin
      if (seg_last) begin
        word_cnt <= 10'd0;
        seg_idx  <= seg_idx + 3'd1;
      end else begin
        word_cnt <= word_cnt + 10'd1;
      end
    end
  end

  dilithium_reg_slice #(
    .DW (TW)
  ) u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .in_data   (slice_in),
    .in_valid  (slice_in_valid),
    .in_ready  (slice_in_ready),
    .out_data  (slice_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_data       = slice_out[W-1:0];
  assign out_seg        = slice_out[W+2:W];
  assign out_seg_first  = slice_out[W+3];
  assign out_seg_last   = slice_out[W+4];
  assign out_frame_last = slice_out[W+5];

endmodule
`default_nettype wire

// File: tb/tb_dilithium_out_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_dilithium_out_framer
// Brief  : Scoreboard bench: level-2 framer at W=32 (dut0) and W=64 (dut1).
// Rev    : 1.0  initial release
// ============================================================================
module tb_dilithium_out_framer;

  localparam logic [1:0] M_KG  = 2'b00;
  localparam logic [1:0] M_SG  = 2'b10;
  localparam logic [1:0] M_VF  = 2'b01;
  localparam logic [1:0] M_BAD = 2'b11;

  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  seg;
    logic        f;
    logic        l;
    logic        fl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, abort0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic        sf0, sl0, fl0, busy0, done0, err0;
  logic [1:0]  mode0;
  logic [2:0]  seg0;
  logic [31:0] in_data0, out_data0;
  logic        start1, abort1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic        sf1, sl1, fl1, busy1, done1, err1;
  logic [1:0]  mode1;
  logic [2:0]  seg1;
  logic [63:0] in_data1, out_data1;

  dilithium_out_framer #(.HIGH_PERF(0), .SEC_LEVEL(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .abort(abort0),
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_seg(seg0), .out_seg_first(sf0), .out_seg_last(sl0), .out_frame_last(fl0),
    .busy(busy0), .done(done0), .err_mode(err0)
  );

  dilithium_out_framer #(.HIGH_PERF(1), .SEC_LEVEL(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .abort(abort1),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_seg(seg1), .out_seg_first(sf1), .out_seg_last(sl1), .out_frame_last(fl1),
    .busy(busy1), .done(done1), .err_mode(err1)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pops0 = 0, pops1 = 0, dcnt0 = 0, dcnt1 = 0, dcyc0 = 0, hs_cyc0 = 0;
  bit   hung = 1'b0;
  bit   rnd_on = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-computed level-2 segment lengths in words
  function automatic int seg_len(input int sel, input logic [1:0] m, input int s);
    if (m == M_KG) begin
      case (s)
        0, 1, 2: return 8;
        3, 4:    return 96;
        5:       return 416;
        default: return 320;
      endcase
    end
    if (m == M_SG) begin
      if (sel == 0) return (s == 0) ? 8 : (s == 1) ? 576 : 21;
      return (s == 0) ? 4 : (s == 1) ? 288 : 11;
    end
    return 1;
  endfunction

  // Scoreboard monitor, W=32 instance
  always @(negedge clk) begin : mon0
    exp_t e;
    logic xd;
    if (rst_n) begin
      xd = 1'b0;
      if (out_valid0) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_word0: got data %h, expected no word", out_data0);
        end else begin
          e = q0[0];
          check("word0", {out_data0, seg0, sf0, sl0, fl0},
                {e.d[31:0], e.seg, e.f, e.l, e.fl});
          if (out_ready0) begin
            xd = e.fl;
            void'(q0.pop_front());
            pops0++;
          end
        end
      end
      if (done0 || xd) check("done0", done0, xd);
      if (done0) begin dcnt0++; dcyc0 = cyc; end
    end
  end

  // Scoreboard monitor, W=64 instance
  always @(negedge clk) begin : mon1
    exp_t e;
    logic xd;
    if (rst_n) begin
      xd = 1'b0;
      if (out_valid1) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_word1: got data %h, expected no word", out_data1);
        end else begin
          e = q1[0];
          check("word1", {out_data1, seg1, sf1, sl1, fl1}, {e.d, e.seg, e.f, e.l, e.fl});
          if (out_ready1) begin
            xd = e.fl;
            void'(q1.pop_front());
            pops1++;
          end
        end
      end
      if (done1 || xd) check("done1", done1, xd);
      if (done1) dcnt1++;
    end
  end

  // Offer one word; push its expectation when the handshake is seen
  task automatic send_word(input int sel, input exp_t e, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    if (sel == 0) begin in_valid0 = 1'b1; in_data0 = e.d[31:0]; end
    else          begin in_valid1 = 1'b1; in_data1 = e.d; end
    t = 0;
    while (1) begin
      @(negedge clk);
      if ((sel == 0) ? in_ready0 : in_ready1) break;
      t++;
      if (t >= 500) break;
      @(posedge clk); #1;
    end
    if (t >= 500) begin
      checks++; failures++; hung = 1'b1;
      $display("FAIL in_ready_timeout: got in_ready=0 for 500 cycles, expected 1");
    end else if (sel == 0) begin
      q0.push_back(e); hs_cyc0 = cyc;
    end else begin
      q1.push_back(e);
    end
    @(posedge clk); #1;
    if (sel == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
  endtask

  // Send up to nmax words of a frame; optionally pulse a stray start at word spur
  task automatic send_frame(input int sel, input logic [1:0] m, input int nmax,
                            input bit gaps, input int spur);
    int   nseg, idx, len;
    exp_t e;
    nseg = (m == M_KG) ? 7 : (m == M_SG) ? 3 : 1;
    idx  = 0;
    for (int s = 0; s < nseg; s++) begin
      len = seg_len(sel, m, s);
      for (int k = 0; k < len; k++) begin
        if (idx >= nmax || hung) return;
        e.seg = 3'(s);
        e.f   = (k == 0);
        e.l   = (k == len - 1);
        e.fl  = e.l && (s == nseg - 1);
        if (m == M_VF)     e.d = 64'h1;
        else if (sel == 0) e.d = {32'h0, 32'(idx)};
        else               e.d = {~32'(idx), 32'(idx)};
        if (sel == 0) begin
          start0 = (idx == spur);
          if (idx == spur) mode0 = M_KG;
        end
        send_word(sel, e, gaps);
        idx++;
      end
    end
    start0 = 1'b0;
  endtask

  task automatic start_frame(input int sel, input logic [1:0] m);
    if (sel == 0) begin start0 = 1'b1; mode0 = m; end
    else          begin start1 = 1'b1; mode1 = m; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int want);
    int t;
    t = 0;
    while (((sel == 0) ? dcnt0 : dcnt1) < want && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    check((sel == 0) ? "done_count0" : "done_count1", (sel == 0) ? dcnt0 : dcnt1, want);
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; mode0 = M_KG; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; mode1 = M_KG; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset0", {in_ready0, out_valid0, sf0, sl0, fl0, busy0, done0, err0, seg0, out_data0}, 0);
    check("reset1", {in_ready1, out_valid1, sf1, sl1, fl1, busy1, done1, err1, seg1, out_data1}, 0);
    @(posedge clk); #1;

    // SIGN, continuous flow, stray start mid-frame
    start_frame(0, M_SG);
    send_frame(0, M_SG, 100000, 1'b0, 300);
    @(negedge clk);
    check("sign_drain_state", {in_ready0, busy0}, 2'b01);
    wait_done(0, 1);
    check("sign_done_latency", dcyc0 - hs_cyc0, 1);
    check("sign_words", pops0, 605);

    // KEYGEN, continuous flow
    start_frame(0, M_KG);
    send_frame(0, M_KG, 100000, 1'b0, -1);
    @(negedge clk);
    check("keygen_in_ready_drop", {in_ready0, busy0}, 2'b01);
    wait_done(0, 2);
    check("keygen_done_latency", dcyc0 - hs_cyc0, 1);
    check("keygen_words", pops0, 1557);

    // W=64 SIGN
    start_frame(1, M_SG);
    send_frame(1, M_SG, 100000, 1'b0, -1);
    @(negedge clk);
    check("w64_drain_state", {in_ready1, busy1}, 2'b01);
    wait_done(1, 1);
    check("w64_words", pops1, 303);

    // Random back-pressure with input gaps: SIGN then VERIFY
    rnd_on = 1'b1;
    fork
      begin
        start_frame(0, M_SG);
        send_frame(0, M_SG, 100000, 1'b1, -1);
        wait_done(0, 3);
        start_frame(0, M_VF);
        send_frame(0, M_VF, 100000, 1'b1, -1);
        wait_done(0, 4);
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready0 = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready0 = 1'b1;
    check("random_words", pops0, 2163);

    // Illegal mode
    start0 = 1'b1; mode0 = M_BAD;
    @(negedge clk);
    check("err_mode_pulse", {err0, busy0}, 2'b10);
    @(posedge clk); #1;
    start0 = 1'b0; mode0 = M_KG;
    @(negedge clk);
    check("err_mode_clear", {err0, busy0}, 2'b00);
    // start and abort together: abort wins
    @(posedge clk); #1;
    start0 = 1'b1; mode0 = M_SG; abort0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; abort0 = 1'b0;
    @(negedge clk);
    check("start_abort_idle", {busy0, in_ready0}, 2'b00);
    @(posedge clk); #1;

    // Abort with Z word 100 held in the slice
    start_frame(0, M_SG);
    send_frame(0, M_SG, 109, 1'b0, -1);
    out_ready0 = 1'b0; abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0; q0.delete(); out_ready0 = 1'b1;
    @(negedge clk);
    check("abort_flush", {out_valid0, busy0, in_ready0, done0}, 4'b0000);
    check("abort_no_done", dcnt0, 4);
    @(posedge clk); #1;
    start_frame(0, M_SG);
    send_frame(0, M_SG, 100000, 1'b0, -1);
    wait_done(0, 5);
    check("restart_words", pops0, 2876);

    // Reset in the middle of KEYGEN
    start_frame(0, M_KG);
    send_frame(0, M_KG, 50, 1'b0, -1);
    out_ready0 = 1'b0; rst_n = 1'b0; in_valid0 = 1'b1; in_data0 = 32'hDEADBEEF;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid0 = 1'b0; q0.delete(); out_ready0 = 1'b1;
    @(negedge clk);
    check("reset_mid_frame",
          {in_ready0, out_valid0, sf0, sl0, fl0, busy0, done0, err0, seg0, out_data0}, 0);
    @(posedge clk); #1;
    start_frame(0, M_VF);
    send_frame(0, M_VF, 100000, 1'b0, -1);
    wait_done(0, 6);
    check("verify_after_reset_words", pops0, 2926);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
